// File: rtl/victim_cache_pkg.sv
// Shared types, sizes and small helpers for the 8-entry victim cache.
package victim_cache_pkg;

  localparam int VC_ENTRIES = 8;
  localparam int VC_IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WB     = 2'd2,
    UPDATE = 2'd3
  } vc_state_e;

  // One-hot decode of a slot index.
  function automatic logic [VC_ENTRIES-1:0] onehot8(input logic [VC_IDX_W-1:0] idx);
    logic [VC_ENTRIES-1:0] one;
    one = 8'h01;
    return one << idx;
  endfunction

  // Index of the set bit of a one-hot vector (highest set bit wins if not one-hot).
  function automatic logic [VC_IDX_W-1:0] oh2idx(input logic [VC_ENTRIES-1:0] oh);
    logic [VC_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < VC_ENTRIES; i++) begin
      r = oh[i] ? VC_IDX_W'(i) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_tag_match.sv
// Parallel tag compare against all valid slots plus lowest-free-slot priority encoder.
module vc_tag_match #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 26,
  parameter int IDX_W   = 3
) (
  input  logic [ENTRIES-1:0][TAG_W-1:0] tags_i,
  input  logic [ENTRIES-1:0]            valid_i,
  input  logic [TAG_W-1:0]              tag_i,
  output logic                          hit_o,
  output logic [IDX_W-1:0]              hit_idx_o,
  output logic                          has_free_o,
  output logic [IDX_W-1:0]              free_idx_o
);

  // Scan from the top down so the lowest matching / lowest free index wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_idx_o  = '0;
    has_free_o = 1'b0;
    free_idx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      hit_o      = (valid_i[i] && (tags_i[i] == tag_i)) ? 1'b1 : hit_o;
      hit_idx_o  = (valid_i[i] && (tags_i[i] == tag_i)) ? IDX_W'(i) : hit_idx_o;
      has_free_o = (!valid_i[i]) ? 1'b1 : has_free_o;
      free_idx_o = (!valid_i[i]) ? IDX_W'(i) : free_idx_o;
    end
  end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Sequencer for the 8-entry fully-associative victim cache: lookup, optional
// dirty writeback, then swap/insert/invalidate and LRU "make newest" pulse.
module victim_cache_ctrl
  import victim_cache_pkg::*;
#(
  parameter int ENTRIES = VC_ENTRIES,
  parameter int TAG_W   = 26,
  parameter int DATA_W  = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic               evict_valid,
  input  logic [TAG_W-1:0]   evict_tag,
  input  logic [DATA_W-1:0]  evict_data,
  input  logic               evict_dirty,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [DATA_W-1:0]  resp_data,
  output logic               mem_wb_valid,
  input  logic               mem_wb_ready,
  output logic [TAG_W-1:0]   mem_wb_tag,
  output logic [DATA_W-1:0]  mem_wb_data,
  input  logic [ENTRIES-1:0] lru_number,
  output logic [ENTRIES-1:0] lru_update
);

  vc_state_e state_q, state_d;

  // Slot arrays: only valid/dirty are reset, tag/data are qualified by valid.
  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0]            dirty_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [DATA_W-1:0]             data_q [ENTRIES];

  // Captured request.
  logic              capture_s;
  logic [TAG_W-1:0]  req_tag_q;
  logic              ev_valid_q;
  logic [TAG_W-1:0]  ev_tag_q;
  logic [DATA_W-1:0] ev_data_q;
  logic              ev_dirty_q;

  // Lookup results.
  logic                hit_q, hit_d;
  logic [VC_IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [VC_IDX_W-1:0] victim_idx_q, victim_idx_d;

  logic                tm_hit_s;
  logic [VC_IDX_W-1:0] tm_hit_idx_s;
  logic                tm_has_free_s;
  logic [VC_IDX_W-1:0] tm_free_idx_s;
  logic [VC_IDX_W-1:0] lru_idx_s;

  vc_tag_match #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .IDX_W   (VC_IDX_W)
  ) u_tag_match (
    .tags_i     (tag_q),
    .valid_i    (valid_q),
    .tag_i      (req_tag_q),
    .hit_o      (tm_hit_s),
    .hit_idx_o  (tm_hit_idx_s),
    .has_free_o (tm_has_free_s),
    .free_idx_o (tm_free_idx_s)
  );

  assign lru_idx_s = oh2idx(lru_number);

  // Next-state logic and lookup decisions; victim is the hit slot, else lowest free, else LRU.
  always_comb begin
    state_d      = state_q;
    hit_d        = hit_q;
    hit_idx_d    = hit_idx_q;
    victim_idx_d = victim_idx_q;
    capture_s    = 1'b0;
    case (state_q)
      IDLE: begin
        capture_s = req_valid;
        state_d   = req_valid ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        hit_d        = tm_hit_s;
        hit_idx_d    = tm_hit_idx_s;
        victim_idx_d = tm_hit_s      ? tm_hit_idx_s :
                       tm_has_free_s ? tm_free_idx_s : lru_idx_s;
        state_d      = (!tm_hit_s && ev_valid_q && valid_q[victim_idx_d] && dirty_q[victim_idx_d])
                       ? WB : UPDATE;
      end
      WB: begin
        state_d = mem_wb_ready ? UPDATE : WB;
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture request and evicted L1 line on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_tag_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_tag_q   <= '0;
      ev_data_q  <= '0;
      ev_dirty_q <= 1'b0;
    end else if (capture_s) begin
      req_tag_q  <= req_tag;
      ev_valid_q <= evict_valid;
      ev_tag_q   <= evict_tag;
      ev_data_q  <= evict_data;
      ev_dirty_q <= evict_dirty;
    end
  end

  // Lookup result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      victim_idx_q <= '0;
    end else begin
      hit_q        <= hit_d;
      hit_idx_q    <= hit_idx_d;
      victim_idx_q <= victim_idx_d;
    end
  end

  // Valid/dirty update: store the evicted line, or invalidate on a plain hit (exclusive).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == UPDATE) begin
      if (ev_valid_q) begin
        valid_q[victim_idx_q] <= 1'b1;
        dirty_q[victim_idx_q] <= ev_dirty_q;
      end else if (hit_q) begin
        valid_q[victim_idx_q] <= 1'b0;
        dirty_q[victim_idx_q] <= 1'b0;
      end
    end
  end

  // Tag/data write of the evicted line; unreset storage.
  always_ff @(posedge clk) begin
    if ((state_q == UPDATE) && ev_valid_q) begin
      tag_q[victim_idx_q]  <= ev_tag_q;
      data_q[victim_idx_q] <= ev_data_q;
    end
  end

  // Output decode from state; resp_data reads the slot before this cycle's write.
  always_comb begin
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    resp_data    = '0;
    mem_wb_valid = 1'b0;
    mem_wb_tag   = '0;
    mem_wb_data  = '0;
    lru_update   = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      LOOKUP: begin
        req_ready = 1'b0;
      end
      WB: begin
        mem_wb_valid = 1'b1;
        mem_wb_tag   = tag_q[victim_idx_q];
        mem_wb_data  = data_q[victim_idx_q];
      end
      UPDATE: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        resp_data  = hit_q ? data_q[hit_idx_q] : '0;
        lru_update = ev_valid_q ? onehot8(victim_idx_q) : '0;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Scoreboard bench for victim_cache_ctrl: a slot-level reference model predicts
// responses and writebacks at issue time; a monitor checks whatever the DUT presents.
module tb_victim_cache_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [25:0]  req_tag = '0;
  logic         evict_valid = 1'b0;
  logic [25:0]  evict_tag = '0;
  logic [127:0] evict_data = '0;
  logic         evict_dirty = 1'b0;
  logic         resp_valid;
  logic         resp_hit;
  logic [127:0] resp_data;
  logic         mem_wb_valid;
  logic         mem_wb_ready = 1'b0;
  logic [25:0]  mem_wb_tag;
  logic [127:0] mem_wb_data;
  logic [7:0]   lru_number = 8'h01;
  logic [7:0]   lru_update;

  victim_cache_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tag      (req_tag),
    .evict_valid  (evict_valid),
    .evict_tag    (evict_tag),
    .evict_data   (evict_data),
    .evict_dirty  (evict_dirty),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_data    (resp_data),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ready (mem_wb_ready),
    .mem_wb_tag   (mem_wb_tag),
    .mem_wb_data  (mem_wb_data),
    .lru_number   (lru_number),
    .lru_update   (lru_update)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         hit;
    logic [127:0] data;
    logic [7:0]   lru;
    int           acc;
  } exp_t;
  typedef struct {
    logic [25:0]  tag;
    logic [127:0] data;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];

  // Reference model: what each of the 8 slots holds.
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [25:0]  m_tag   [8];
  logic [127:0] m_data  [8];

  int wb_mode = 1;   // 0 random ready, 1 always ready, 2 never ready
  int wb_cnt  = 0;
  int prev_acc = 0;
  int prev_wb  = 0;
  bit have_prev = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int m_find(input logic [25:0] t);
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endfunction

  // Writeback ready driver, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wb_mode == 0) mem_wb_ready = 1'($urandom % 2);
      else if (wb_mode == 1) mem_wb_ready = 1'b1;
      else mem_wb_ready = 1'b0;
    end
  end

  // Monitor: compares every presented response / writeback with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        wb_cnt = 0;
        continue;
      end
      if ($countones(lru_update) > 1) chk("lru_multihot", lru_update, 0);
      if (mem_wb_valid) begin
        wb_cnt++;
        if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          chk("wb_tag", mem_wb_tag, wb_q[0].tag);
          chk("wb_data", mem_wb_data, wb_q[0].data);
          if (mem_wb_ready) void'(wb_q.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_hit", resp_hit, e.hit);
          chk("resp_data", resp_data, e.data);
          chk("lru_update", lru_update, e.lru);
          chk("resp_latency", cyc, e.acc + 2 + wb_cnt);
        end
        wb_cnt = 0;
      end else begin
        chk("lru_idle_zero", lru_update, 0);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) chk("req_ready_timeout", 0, 1);
  endtask

  // Issue one request; the model is advanced and expectations pushed at issue.
  task automatic do_req(input logic [25:0] rt, input bit ev, input logic [25:0] et,
                        input logic [127:0] ed, input bit edirty, input logic [7:0] lru,
                        input bit b2b);
    bit   ok;
    int   h;
    int   s;
    exp_t e;
    int   got_wb;
    wait_ready(ok);
    if (!ok) return;
    if (b2b && have_prev) chk("accept_gap", cyc - prev_acc, 3 + prev_wb);
    req_tag = rt; evict_valid = ev; evict_tag = et; evict_data = ed;
    evict_dirty = edirty; lru_number = lru; req_valid = 1'b1;
    got_wb = 0;
    e.acc = cyc;
    h = m_find(rt);
    if (h >= 0) begin
      e.hit  = 1'b1;
      e.data = m_data[h];
      if (ev) begin
        m_tag[h] = et; m_data[h] = ed; m_dirty[h] = edirty;
        e.lru = 8'(1 << h);
      end else begin
        m_valid[h] = 0; m_dirty[h] = 0;
        e.lru = 8'h00;
      end
    end else begin
      e.hit  = 1'b0;
      e.data = '0;
      if (ev) begin
        s = -1;
        for (int i = 0; i < 8; i++) if (!m_valid[i] && s < 0) s = i;
        if (s < 0) for (int i = 0; i < 8; i++) if (lru[i]) s = i;
        if (m_valid[s] && m_dirty[s]) begin
          wb_q.push_back('{tag: m_tag[s], data: m_data[s]});
          got_wb = 1;
        end
        m_valid[s] = 1; m_dirty[s] = edirty; m_tag[s] = et; m_data[s] = ed;
        e.lru = 8'(1 << s);
      end else begin
        e.lru = 8'h00;
      end
    end
    exp_q.push_back(e);
    prev_acc = cyc; prev_wb = got_wb; have_prev = 1;
    @(posedge clk);
    if (!b2b) begin
      #1 req_valid = 1'b0;
    end
  endtask

  function automatic logic [127:0] rdata();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_req(input bit b2b);
    logic [25:0] rt, et;
    bit ev;
    int k;
    rt = 26'h100 + 26'($urandom_range(0, 15));
    if ($urandom % 2 == 1) begin
      k = $urandom_range(0, 7);
      if (m_valid[k]) rt = m_tag[k];
    end
    ev = ($urandom % 4) != 0;
    et = 26'h100 + 26'($urandom_range(0, 15));
    while (et == rt || m_find(et) >= 0) et = 26'h100 + 26'($urandom_range(0, 15));
    do_req(rt, ev, et, rdata(), 1'($urandom % 2), 8'(1 << $urandom_range(0, 7)), b2b);
  endtask

  task automatic wait_wb_valid();
    int n = 0;
    while (!mem_wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_wb_valid) chk("wb_valid_timeout", 0, 1);
  endtask

  initial begin
    m_reset();
    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mem_wb_valid", mem_wb_valid, 0);
    chk("rst_mem_wb_tag", mem_wb_tag, 0);
    chk("rst_lru_update", lru_update, 0);
    @(negedge clk); #2 reset = 1'b1;

    // 1: first insert lands in slot 0
    do_req(26'h10, 1, 26'h20, rdata(), 0, 8'h01, 0);
    // 2: fill slots 1..7 dirty, then swap-hit on 0x23
    for (int i = 1; i < 8; i++) do_req(26'h80 + 26'(i), 1, 26'h20 + 26'(i), rdata(), 1, 8'h01, 0);
    do_req(26'h23, 1, 26'h30, rdata(), 1, 8'h01, 0);
    // 3: full, LRU slot 5 dirty -> writeback held for 3 cycles
    wb_mode = 2;
    do_req(26'h90, 1, 26'h40, rdata(), 1, 8'h20, 0);
    wait_wb_valid();
    repeat (3) @(negedge clk);
    wb_mode = 1;
    // 4: plain hit invalidates slot 1, next insert reuses it
    do_req(26'h21, 0, 26'h0, '0, 0, 8'h80, 0);
    do_req(26'h91, 1, 26'h41, rdata(), 1, 8'h80, 0);
    do_req(26'h41, 0, 26'h0, '0, 0, 8'h80, 0);
    do_req(26'h93, 1, 26'h43, rdata(), 0, 8'h80, 0);
    // 5: reset during writeback
    wb_mode = 2;
    do_req(26'h92, 1, 26'h42, rdata(), 1, 8'h04, 0);
    @(negedge clk);
    wait_wb_valid();
    #2 reset = 1'b0;
    #1;
    chk("rst_wb_drop", mem_wb_valid, 0);
    chk("rst_no_resp", resp_valid, 0);
    chk("rst_mid_ready", req_ready, 1);
    exp_q.delete();
    wb_q.delete();
    m_reset();
    wb_mode = 1;
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("post_rst_ready", req_ready, 1);
    do_req(26'h30, 1, 26'h31, rdata(), 1, 8'h01, 0);

    // Random traffic with random writeback back-pressure
    wb_mode = 0;
    for (int i = 0; i < 250; i++) rand_req(0);

    // 6: back-to-back with req_valid held high
    wb_mode = 1;
    have_prev = 0;
    for (int i = 0; i < 60; i++) rand_req(1);
    #1 req_valid = 1'b0;

    for (int n = 0; n < 50 && (exp_q.size() != 0 || wb_q.size() != 0); n++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
